// File: rtl/ram_io_pkg.sv
// Shared decode constants and helpers for the RAM/I-O byte-bus responder.
package ram_io_pkg;

  localparam logic [1:0] IO_SEL     = 2'b11;
  localparam logic [2:0] IO_DATA    = 3'd0;
  localparam logic [2:0] IO_CTRL    = 3'd4;
  localparam int         ST_TX_FULL = 0;
  localparam int         ST_RX_NE   = 1;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_CTRL = 2'd1,
    REG_NONE = 2'd2
  } io_reg_e;

  function automatic io_reg_e decode_reg(input logic [2:0] off);
    if (off == IO_DATA) begin
      return REG_DATA;
    end else if (off == IO_CTRL) begin
      return REG_CTRL;
    end else begin
      return REG_NONE;
    end
  endfunction

  function automatic logic [7:0] status_byte(input logic rx_ne, input logic tx_full);
    logic [7:0] s;
    s             = 8'h00;
    s[ST_RX_NE]   = rx_ne;
    s[ST_TX_FULL] = tx_full;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through byte FIFO with wrap-bit pointers; a push on a full
// FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [7:0]       mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; a write during reset is harmless since pointers clear.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/ram_io_resp.sv
// Byte-bus responder: synchronous RAM plus an I/O window with UART TX/RX FIFOs,
// status and halt registers. Read data always appears one cycle after the address.
module ram_io_resp
  import ram_io_pkg::*;
#(
  parameter int          RAM_AW  = 17,
  parameter int          FIFO_AW = 4,
  parameter logic [31:0] IO_BASE = {14'd0, IO_SEL, 16'd0}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_in,
  input  logic        wr_in,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        halt,
  output logic [7:0]  halt_code,
  output logic        ovf
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  logic [7:0]        ram_q [RAM_DEPTH];
  logic [7:0]        ram_rd_q;
  logic [RAM_AW-1:0] ram_idx_s;

  logic        io_s;
  logic        fresh_s;
  io_reg_e     reg_s;

  logic        tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
  logic        rx_pop_s, rx_full_s, rx_empty_s;
  logic [7:0]  rx_head_s;
  logic [7:0]  io_rd_s;
  logic        halt_set_s;
  logic        ovf_set_s;

  logic [31:0] prev_a_q;
  logic        prev_wr_q;
  logic        sel_ram_q, sel_ram_d;
  logic [7:0]  d_out_q, d_out_d;
  logic        halt_q, halt_d;
  logic [7:0]  halt_code_q, halt_code_d;
  logic        ovf_q, ovf_d;

  assign ram_idx_s = a_in[RAM_AW-1:0];
  assign io_s      = (a_in[17:16] == IO_BASE[17:16]);
  assign fresh_s   = (a_in != prev_a_q) || (wr_in != prev_wr_q);
  assign reg_s     = decode_reg(a_in[2:0]);
  assign tx_pop_s  = tx_ready && !tx_empty_s;

  // I/O register decode: read mux and side effects, each gated by a fresh access.
  always_comb begin
    io_rd_s    = 8'h00;
    tx_push_s  = 1'b0;
    rx_pop_s   = 1'b0;
    halt_set_s = 1'b0;
    if (io_s) begin
      case (reg_s)
        REG_DATA: begin
          if (wr_in) begin
            tx_push_s = fresh_s;
          end else begin
            io_rd_s  = rx_empty_s ? 8'h00 : rx_head_s;
            rx_pop_s = fresh_s && !rx_empty_s;
          end
        end
        REG_CTRL: begin
          if (wr_in) begin
            halt_set_s = fresh_s;
          end else begin
            io_rd_s = status_byte(!rx_empty_s, tx_full_s);
          end
        end
        default: begin
          io_rd_s = 8'h00;
        end
      endcase
    end else begin
      io_rd_s = 8'h00;
    end
  end

  assign ovf_set_s = (tx_push_s && tx_full_s && !tx_pop_s) ||
                     (rx_valid && rx_full_s && !rx_pop_s);

  always_comb begin
    sel_ram_d   = !wr_in && !io_s;
    halt_d      = halt_q || halt_set_s;
    ovf_d       = ovf_q || ovf_set_s;
    d_out_d     = d_in;
    halt_code_d = halt_code_q;
    if (wr_in) begin
      d_out_d = d_in;
    end else begin
      d_out_d = io_rd_s;
    end
    if (halt_set_s) begin
      halt_code_d = d_in;
    end else begin
      halt_code_d = halt_code_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_a_q    <= 32'hFFFF_FFFF;
      prev_wr_q   <= 1'b0;
      sel_ram_q   <= 1'b0;
      d_out_q     <= 8'h00;
      halt_q      <= 1'b0;
      halt_code_q <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      prev_a_q    <= a_in;
      prev_wr_q   <= wr_in;
      sel_ram_q   <= sel_ram_d;
      d_out_q     <= d_out_d;
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      ovf_q       <= ovf_d;
    end
  end

  // Write-first behaviour comes from the d_in path above, so the array read can stay read-old.
  always_ff @(posedge clk) begin
    if (wr_in && !io_s) begin
      ram_q[ram_idx_s] <= d_in;
    end
    ram_rd_q <= ram_q[ram_idx_s];
  end

  byte_fifo #(.FIFO_AW(FIFO_AW)) u_tx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tx_push_s),
    .din  (d_in),
    .pop  (tx_pop_s),
    .dout (tx_data),
    .full (tx_full_s),
    .empty(tx_empty_s)
  );

  byte_fifo #(.FIFO_AW(FIFO_AW)) u_rx_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (rx_valid),
    .din  (rx_data),
    .pop  (rx_pop_s),
    .dout (rx_head_s),
    .full (rx_full_s),
    .empty(rx_empty_s)
  );

  assign d_out     = sel_ram_q ? ram_rd_q : d_out_q;
  assign tx_valid  = !tx_empty_s;
  assign halt      = halt_q;
  assign halt_code = halt_code_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ram_io_resp.sv
// Bench for ram_io_resp: directed scenarios plus random traffic against a queue-based model.
module tb_ram_io_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_in;
  logic        wr_in;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        halt;
  logic [7:0]  halt_code;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_io_resp dut (
    .clk      (clk),
    .rst      (rst),
    .a_in     (a_in),
    .wr_in    (wr_in),
    .d_in     (d_in),
    .d_out    (d_out),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .halt     (halt),
    .halt_code(halt_code),
    .ovf      (ovf)
  );

  logic [7:0]  mem_m [int];
  logic [7:0]  tx_m [$];
  logic [7:0]  rx_m [$];
  logic [31:0] prev_a_m;
  logic        prev_wr_m;
  logic        ovf_m;
  logic        halt_m;
  logic [7:0]  code_m;
  logic [7:0]  last_exp;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    check_val("tx_valid", 32'(tx_valid), 32'(tx_m.size() > 0));
    if (tx_m.size() > 0) check_val("tx_data", 32'(tx_data), 32'(tx_m[0]));
    check_val("halt", 32'(halt), 32'(halt_m));
    check_val("halt_code", 32'(halt_code), 32'(code_m));
    check_val("ovf", 32'(ovf), 32'(ovf_m));
  endtask

  task automatic do_reset();
    rst = 1'b1; a_in = 32'h0; wr_in = 1'b0; d_in = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    tx_m.delete(); rx_m.delete();
    prev_a_m = 32'hFFFF_FFFF; prev_wr_m = 1'b0;
    ovf_m = 1'b0; halt_m = 1'b0; code_m = 8'h00;
    check_val("rst_d_out", 32'(d_out), 32'h0);
    check_outs();
  endtask

  // One bus cycle: expectation from the pre-edge model state, then the model update.
  task automatic step(input logic [31:0] a, input logic wr, input logic [7:0] d,
                      input logic txr, input logic rxv, input logic [7:0] rxd);
    logic       io, fresh, known, txp, rxp;
    logic [2:0] off;
    logic [7:0] exp_d;
    int         idx, txn, rxn;
    a_in = a; wr_in = wr; d_in = d; tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    io    = (a[17:16] == 2'b11);
    off   = a[2:0];
    fresh = (a != prev_a_m) || (wr != prev_wr_m);
    idx   = int'(a[16:0]);
    txn   = tx_m.size();
    rxn   = rx_m.size();
    known = 1'b1;
    exp_d = 8'h00;
    if (wr) exp_d = d;
    else if (io) begin
      if (off == 3'd0) exp_d = (rxn > 0) ? rx_m[0] : 8'h00;
      else if (off == 3'd4) exp_d = {6'b0, rxn > 0, txn == 16};
    end else if (mem_m.exists(idx)) exp_d = mem_m[idx];
    else known = 1'b0;
    txp = txr && (txn > 0);
    rxp = !wr && io && (off == 3'd0) && fresh && (rxn > 0);
    @(posedge clk); #1;
    if (txp) void'(tx_m.pop_front());
    if (rxp) void'(rx_m.pop_front());
    if (wr && io && off == 3'd0 && fresh) begin
      if (txn < 16 || txp) tx_m.push_back(d); else ovf_m = 1'b1;
    end
    if (rxv) begin
      if (rxn < 16 || rxp) rx_m.push_back(rxd); else ovf_m = 1'b1;
    end
    if (wr && !io) mem_m[idx] = d;
    if (wr && io && off == 3'd4 && fresh) begin halt_m = 1'b1; code_m = d; end
    prev_a_m = a; prev_wr_m = wr;
    last_exp = exp_d;
    if (known) check_val("d_out", 32'(d_out), 32'(exp_d));
    check_outs();
  endtask

  task automatic idle();
    step(32'h0003_0001, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [31:0] a, prev_rand_a;
    do_reset();

    // RAM sequence, with 0x104/0x105 preloaded as the prior contents
    step(32'h104, 1'b1, 8'hC4, 1'b0, 1'b0, 8'h00);
    step(32'h105, 1'b1, 8'hC5, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(32'h100 + 32'(i), 1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step(32'h100 + 32'(i), 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      if (i == 0) check_val("ram_first", 32'(d_out), 32'h11);
      if (i == 3) check_val("ram_fourth", 32'(d_out), 32'h44);
    end

    // Read-during-write and aliased read-back
    step(32'h40, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
    check_val("rdw", 32'(d_out), 32'hA5);
    step(32'h40, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check_val("rdw_back", 32'(d_out), 32'hA5);
    step(32'hFFF2_0040, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // TX path
    step(32'h0003_0000, 1'b1, 8'h48, 1'b0, 1'b0, 8'h00);
    idle();
    step(32'h0003_0000, 1'b1, 8'h69, 1'b0, 1'b0, 8'h00);
    check_val("tx_head", 32'(tx_data), 32'h48);
    step(32'h0003_0001, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    step(32'h0003_0001, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    check_val("tx_drained", 32'(tx_valid), 32'h0);
    for (int i = 0; i < 5; i++) step(32'h0003_0000, 1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 8'h00);
    step(32'h0003_0001, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    check_val("hold_one_push", 32'(tx_valid), 32'h0);

    // RX path
    step(32'h0003_0001, 1'b0, 8'h00, 1'b0, 1'b1, 8'h7A);
    step(32'h0003_0004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check_val("status_rx", 32'(d_out), 32'h02);
    step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check_val("rx_byte", 32'(d_out), 32'h7A);
    idle();
    step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check_val("rx_empty", 32'(d_out), 32'h00);
    step(32'h0003_0001, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB1);
    step(32'h0003_0001, 1'b0, 8'h00, 1'b0, 1'b1, 8'hB2);
    for (int i = 0; i < 3; i++) step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    idle();
    step(32'h0003_0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check_val("rx_hold_one_pop", 32'(d_out), 32'hB2);

    // Overflow: 17 fresh pushes by alternating aliased I/O addresses
    do_reset();
    for (int i = 0; i < 17; i++)
      step((i % 2 == 0) ? 32'h0003_0000 : 32'h0007_0000, 1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
    check_val("ovf_set", 32'(ovf), 32'h1);
    step(32'h0003_0004, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    check_val("status_full", 32'(d_out), 32'h01);
    // Full FIFO with same-cycle pop accepts the push
    step(32'h0003_0000, 1'b1, 8'hEE, 1'b1, 1'b0, 8'h00);
    do_reset();
    check_val("ovf_clr", 32'(ovf), 32'h0);

    // Halt
    step(32'h0003_0004, 1'b1, 8'h05, 1'b0, 1'b0, 8'h00);
    check_val("halt_set", 32'(halt), 32'h1);
    check_val("halt_code_set", 32'(halt_code), 32'h05);
    step(32'h100, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(32'h0003_0000, 1'b1, 8'h33, 1'b0, 1'b1, 8'h44);

    // Random traffic, including occasional mid-operation resets
    prev_rand_a = 32'h100;
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 5))
        0: a = 32'h100 + 32'($urandom_range(0, 7));
        1: a = 32'h0003_0000;
        2: a = 32'h0003_0004;
        3: a = 32'h0003_0000 | (32'($urandom_range(0, 3)) << 18) | 32'($urandom_range(0, 7));
        4: a = 32'h40 | (32'($urandom_range(0, 1)) << 24);
        default: a = prev_rand_a;
      endcase
      prev_rand_a = a;
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(a, $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
